stage_2_inv_stream_permutation: RTL and testbench
=================================================

STAGE_2_INV_STREAM_PERMUTATION -- requirements
Module: stage_2_inv_stream_permutation

Interface
REQ-001 Parameter DATA_WIDTH_PER_INPUT, default 32, SHALL set the width of each data lane.
REQ-002 Parameter INPUT_PER_CYCLE, default 32, SHALL set the lane count; only the value 32 is supported.
REQ-003 Parameter FRAME_CYCLES, default 128, SHALL set the cycles per frame (4096/32); it SHALL be even.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_start  input  1  SHALL be a pulse marking the first data cycle (phase 0) of a frame.
REQ-007 inData_0..inData_31  input  DATA_WIDTH_PER_INPUT each  SHALL carry input lanes 0..31, valid on every cycle of a frame.
REQ-008 outData_0..outData_31  output  DATA_WIDTH_PER_INPUT each  SHALL carry registered output lanes 0..31.
REQ-009 out_start  output  1  SHALL pulse on the first output cycle of a frame.
REQ-010 out_valid  output  1  SHALL be high on every output cycle that carries frame data.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN. It SHALL go IDLE->RUN on in_start. It SHALL go RUN->IDLE after phase FRAME_CYCLES-1 if in_start is low on the following cycle.
REQ-012 A 7-bit phase counter SHALL load 0 on in_start and increment each RUN cycle. An in_start on the cycle after phase 127 SHALL start the next frame with no gap.
REQ-013 Pairing: the input at an even phase is A, and the input at the next odd phase is B.
REQ-014 Temporal exchange: X SHALL be {A[0..15] in lanes 0-15, B[0..15] in lanes 16-31}. Y SHALL be {A[16..31] in lanes 0-15, B[16..31] in lanes 16-31}.
REQ-015 Spatial inverse: p(j) SHALL be j with bits 0 and 3 swapped and bit 4 kept. outData_j SHALL equal X[p(j)] or Y[p(j)].
REQ-016 Latency SHALL be exactly 2 cycles per word: A at cycle t yields X at cycle t+2, and B at cycle t+1 yields Y at cycle t+3.
REQ-017 out_start SHALL be high exactly 2 cycles after each accepted in_start and low otherwise.
REQ-018 out_valid SHALL be high 2 cycles after each cycle where the FSM is RUN with a complete pair.
REQ-019 The idle output: when out_valid is low, every outData_j SHALL be 0.
REQ-020 Inputs SHALL be ignored in IDLE.
REQ-021 An in_start arriving while a pair is incomplete (the previous cycle was an even phase) SHALL:
- discard the buffered A;
- drive zeros with out_valid low in that A's output slot;
- treat the current cycle as phase 0.
REQ-022 An in_start in RUN at any phase SHALL restart the frame; the accepted in_start always wins over the counter wrap.
REQ-023 The buffering SHALL be at most one half-pair buffer (A) plus one Y buffer plus the output registers; no frame-sized RAM.

Reset
REQ-024 While rst is low, all outputs SHALL be 0, the FSM SHALL be IDLE, and the phase and buffers SHALL be cleared, asynchronously.
REQ-025 A reset asserted mid-frame SHALL abandon the frame. After deassertion, no output SHALL be valid until a new in_start has been accepted and 2 cycles have elapsed.

Verification
REQ-026 Single frame: in_start at cycle 0, inData_k = 100*c + k in cycle c.
- cycle 2: out_start=1, out_valid=1, outData_1=8, outData_16=100, outData_17=108.
- cycle 3: outData_0=16, outData_1=24, outData_17=124.
REQ-027 Frame end: after phase 127, with no further in_start:
- out_valid is high for exactly cycles 2..129;
- all outData are 0 from cycle 130;
- the FSM returns to IDLE.
REQ-028 Back-to-back frames: in_start at cycles 0 and 128 -> out_valid continuously high on cycles 2..257, with out_start at cycles 2 and 130.
REQ-029 Truncated pair: in_start at 0, then again at 5 (phase 5 is A of a new pair; prior pair 4 incomplete).
- cycle 6: zeros, out_valid=0.
- cycle 7: out_start=1.
REQ-030 Async reset: rst low at cycle 40 (between edges) -> outputs 0 immediately, with no clock edge needed. After release, in_start at cycle 50 gives out_start at cycle 52 only.
REQ-031 Idle noise: random inData with in_start low for 200 cycles after reset -> all outputs remain 0 and out_valid stays 0.

Source files
------------

// File: rtl/stage_2_inv_stream_permutation.sv
// Stage-2 inverse stream permutation: pairs consecutive 32-lane words (A, B), swaps their
// half-words in time into X and Y, then reorders lanes by swapping index bits 0 and 3.
module stage_2_inv_stream_permutation #(
   parameter int DATA_WIDTH_PER_INPUT = 32,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int FRAME_CYCLES         = 128
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_start,
   input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,  inData_1,  inData_2,  inData_3,
                                           inData_4,  inData_5,  inData_6,  inData_7,
                                           inData_8,  inData_9,  inData_10, inData_11,
                                           inData_12, inData_13, inData_14, inData_15,
                                           inData_16, inData_17, inData_18, inData_19,
                                           inData_20, inData_21, inData_22, inData_23,
                                           inData_24, inData_25, inData_26, inData_27,
                                           inData_28, inData_29, inData_30, inData_31,
   output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,  outData_1,  outData_2,  outData_3,
                                           outData_4,  outData_5,  outData_6,  outData_7,
                                           outData_8,  outData_9,  outData_10, outData_11,
                                           outData_12, outData_13, outData_14, outData_15,
                                           outData_16, outData_17, outData_18, outData_19,
                                           outData_20, outData_21, outData_22, outData_23,
                                           outData_24, outData_25, outData_26, outData_27,
                                           outData_28, outData_29, outData_30, outData_31,
   output logic                            out_start,
   output logic                            out_valid
);
   localparam int DW    = DATA_WIDTH_PER_INPUT;
   localparam int LANES = INPUT_PER_CYCLE;
   localparam int HALF  = LANES / 2;
   localparam logic [6:0] LAST_PHASE = 7'(FRAME_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   function automatic logic [4:0] perm(input logic [4:0] j);
      return {j[4], j[0], j[2], j[1], j[3]};
   endfunction

   logic [LANES-1:0][DW-1:0] in_s;
   logic [LANES-1:0][DW-1:0] x_word_s, y_word_s, x_perm_s, y_perm_s;
   logic [LANES-1:0][DW-1:0] a_buf_r, y_buf_r, out_r;
   state_t     state_r;
   logic [6:0] phase_r;
   logic       a_valid_r, y_pend_r, start_d_r, out_start_r, out_valid_r;
   logic       active_s, odd_s, a_take_s, x_fire_s;

   assign in_s = {inData_31, inData_30, inData_29, inData_28, inData_27, inData_26, inData_25, inData_24,
                  inData_23, inData_22, inData_21, inData_20, inData_19, inData_18, inData_17, inData_16,
                  inData_15, inData_14, inData_13, inData_12, inData_11, inData_10, inData_9,  inData_8,
                  inData_7,  inData_6,  inData_5,  inData_4,  inData_3,  inData_2,  inData_1,  inData_0};

   assign {outData_31, outData_30, outData_29, outData_28, outData_27, outData_26, outData_25, outData_24,
           outData_23, outData_22, outData_21, outData_20, outData_19, outData_18, outData_17, outData_16,
           outData_15, outData_14, outData_13, outData_12, outData_11, outData_10, outData_9,  outData_8,
           outData_7,  outData_6,  outData_5,  outData_4,  outData_3,  outData_2,  outData_1,  outData_0} = out_r;
   assign out_start = out_start_r;
   assign out_valid = out_valid_r;

   // Current-cycle pairing decode; an accepted in_start makes this cycle phase 0 (an A word).
   always_comb begin
      active_s = in_start | (state_r == RUN);
      odd_s    = ~in_start & phase_r[0];
      a_take_s = active_s & ~odd_s;
      x_fire_s = active_s & odd_s & a_valid_r;
      for (int j = 0; j < LANES; j++) begin
         if (j < HALF) begin
            x_word_s[j] = a_buf_r[j];
            y_word_s[j] = a_buf_r[j+HALF];
         end else begin
            x_word_s[j] = in_s[j-HALF];
            y_word_s[j] = in_s[j];
         end
      end
      for (int j = 0; j < LANES; j++) begin
         x_perm_s[j] = x_word_s[perm(5'(j))];
         y_perm_s[j] = y_word_s[perm(5'(j))];
      end
   end

   // Frame FSM, phase counter and start pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         phase_r     <= 7'd0;
         start_d_r   <= 1'b0;
         out_start_r <= 1'b0;
      end else begin
         start_d_r   <= in_start;
         out_start_r <= start_d_r;
         if (in_start) begin
            state_r <= RUN;
            phase_r <= 7'd1;
         end else if ((state_r == RUN) && (phase_r != LAST_PHASE)) begin
            state_r <= RUN;
            phase_r <= phase_r + 7'd1;
         end else begin
            state_r <= IDLE;
            phase_r <= 7'd0;
         end
      end
   end

   // Half-pair buffer, Y buffer and output registers; X leaves on B's edge, Y one edge later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_buf_r     <= '0;
         a_valid_r   <= 1'b0;
         y_buf_r     <= '0;
         y_pend_r    <= 1'b0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else begin
         a_valid_r <= a_take_s;
         if (a_take_s) begin
            a_buf_r <= in_s;
         end else begin
            a_buf_r <= a_buf_r;
         end
         if (x_fire_s) begin
            out_r       <= x_perm_s;
            out_valid_r <= 1'b1;
            y_buf_r     <= y_perm_s;
            y_pend_r    <= 1'b1;
         end else if (y_pend_r) begin
            out_r       <= y_buf_r;
            out_valid_r <= 1'b1;
            y_pend_r    <= 1'b0;
         end else begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            y_pend_r    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_stage_2_inv_stream_permutation.sv
// Directed bench for stage_2_inv_stream_permutation: frame-level model plus hand-computed literals.
module tb_stage_2_inv_stream_permutation;
   localparam int DW = 32;
   localparam int FC = 128;
   localparam int NC = 2048;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_start = 1'b0;
   logic [31:0][DW-1:0] in_p = '0;
   logic [31:0][DW-1:0] out_p;
   logic out_start, out_valid;

   bit [DW-1:0] hist  [NC][32];
   bit [DW-1:0] exp_d [NC][32];
   bit          exp_v [NC];
   bit          exp_s [NC];
   int g_cyc = -1;
   int base = 0;
   int frame_start = -1;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   stage_2_inv_stream_permutation #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(32), .FRAME_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .in_start(in_start),
      .inData_0(in_p[0]),   .inData_1(in_p[1]),   .inData_2(in_p[2]),   .inData_3(in_p[3]),
      .inData_4(in_p[4]),   .inData_5(in_p[5]),   .inData_6(in_p[6]),   .inData_7(in_p[7]),
      .inData_8(in_p[8]),   .inData_9(in_p[9]),   .inData_10(in_p[10]), .inData_11(in_p[11]),
      .inData_12(in_p[12]), .inData_13(in_p[13]), .inData_14(in_p[14]), .inData_15(in_p[15]),
      .inData_16(in_p[16]), .inData_17(in_p[17]), .inData_18(in_p[18]), .inData_19(in_p[19]),
      .inData_20(in_p[20]), .inData_21(in_p[21]), .inData_22(in_p[22]), .inData_23(in_p[23]),
      .inData_24(in_p[24]), .inData_25(in_p[25]), .inData_26(in_p[26]), .inData_27(in_p[27]),
      .inData_28(in_p[28]), .inData_29(in_p[29]), .inData_30(in_p[30]), .inData_31(in_p[31]),
      .outData_0(out_p[0]),   .outData_1(out_p[1]),   .outData_2(out_p[2]),   .outData_3(out_p[3]),
      .outData_4(out_p[4]),   .outData_5(out_p[5]),   .outData_6(out_p[6]),   .outData_7(out_p[7]),
      .outData_8(out_p[8]),   .outData_9(out_p[9]),   .outData_10(out_p[10]), .outData_11(out_p[11]),
      .outData_12(out_p[12]), .outData_13(out_p[13]), .outData_14(out_p[14]), .outData_15(out_p[15]),
      .outData_16(out_p[16]), .outData_17(out_p[17]), .outData_18(out_p[18]), .outData_19(out_p[19]),
      .outData_20(out_p[20]), .outData_21(out_p[21]), .outData_22(out_p[22]), .outData_23(out_p[23]),
      .outData_24(out_p[24]), .outData_25(out_p[25]), .outData_26(out_p[26]), .outData_27(out_p[27]),
      .outData_28(out_p[28]), .outData_29(out_p[29]), .outData_30(out_p[30]), .outData_31(out_p[31]),
      .out_start(out_start), .out_valid(out_valid));

   // Lane j reads pair-word lane p(j): j with bits 0 and 3 exchanged, arithmetic form.
   function automatic int pm(input int j);
      return (j & 22) | ((j & 1) << 3) | ((j >> 3) & 1);
   endfunction

   // Frame-level model: the phase is the distance from the latest accepted in_start; every
   // odd phase closes a pair whose X lands one cycle later and whose Y lands two cycles later.
   task automatic model_cycle();
      int q;
      if (rst !== 1'b1) begin
         frame_start = -1;
         for (int c = g_cyc; c <= g_cyc + 2; c++) begin
            exp_v[c] = 1'b0;
            exp_s[c] = 1'b0;
            for (int k = 0; k < 32; k++) exp_d[c][k] = '0;
         end
      end else begin
         if (in_start === 1'b1) frame_start = g_cyc;
         else if (frame_start >= 0 && (g_cyc - frame_start) >= FC) frame_start = -1;
         if (in_start === 1'b1) exp_s[g_cyc + 2] = 1'b1;
         if (frame_start >= 0 && ((g_cyc - frame_start) % 2) == 1) begin
            exp_v[g_cyc + 1] = 1'b1;
            exp_v[g_cyc + 2] = 1'b1;
            for (int j = 0; j < 32; j++) begin
               q = pm(j);
               exp_d[g_cyc + 1][j] = (q < 16) ? hist[g_cyc - 1][q]      : hist[g_cyc][q - 16];
               exp_d[g_cyc + 2][j] = (q < 16) ? hist[g_cyc - 1][q + 16] : hist[g_cyc][q];
            end
         end
      end
   endtask

   // mode 0: 100*local_cycle + lane, mode 1: random, other: zeros
   task automatic step(input logic r, input logic st, input int mode);
      @(posedge clk);
      #1;
      g_cyc = g_cyc + 1;
      rst = r;
      in_start = st;
      for (int k = 0; k < 32; k++) begin
         case (mode)
            0:       in_p[k] = DW'(100 * (g_cyc - base) + k);
            1:       in_p[k] = $urandom;
            default: in_p[k] = '0;
         endcase
         hist[g_cyc][k] = in_p[k];
      end
      model_cycle();
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] mdl, input logic [31:0] want);
      total++;
      if (got !== want || mdl !== want) begin
         bad++;
         $display("FAIL %s got=%0d model=%0d want=%0d", nm, got, mdl, want);
      end
   endtask

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin : cmp
      int lb;
      if (g_cyc >= 0) begin
         total++;
         if (out_valid !== exp_v[g_cyc]) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", g_cyc, out_valid, exp_v[g_cyc]);
         end
         total++;
         if (out_start !== exp_s[g_cyc]) begin
            bad++;
            $display("FAIL out_start cyc=%0d got=%b want=%b", g_cyc, out_start, exp_s[g_cyc]);
         end
         total++;
         lb = -1;
         for (int k = 0; k < 32; k++) if (lb < 0 && out_p[k] !== exp_d[g_cyc][k]) lb = k;
         if (lb >= 0) begin
            bad++;
            $display("FAIL outData cyc=%0d lane=%0d got=%0d want=%0d", g_cyc, lb, out_p[lb], exp_d[g_cyc][lb]);
         end
      end
   end

   initial begin
      int nv, nvm, fv, fvm, lv, lvm, ns, nsm;
      #2 rst = 1'b0;

      // reset: in_start and data are ignored while rst is low
      for (int c = 0; c < 3; c++) step(1'b0, c == 1, 1);
      lit("rst_valid", 32'(out_valid), 32'(exp_v[g_cyc]), 32'd0);
      lit("rst_start", 32'(out_start), 32'(exp_s[g_cyc]), 32'd0);
      lit("rst_lane0", out_p[0], exp_d[g_cyc][0], 32'd0);

      // idle noise
      nv = 0;
      for (int c = 0; c < 200; c++) begin
         step(1'b1, 1'b0, 1);
         for (int k = 0; k < 32; k++) if (out_p[k] !== '0) nv++;
         if (out_valid !== 1'b0) nv++;
      end
      lit("idle_nonzero", 32'(nv), 32'd0, 32'd0);

      // single frame followed by silence
      base = g_cyc + 1; nv = 0; nvm = 0; fv = -1; fvm = -1; lv = -1; lvm = -1;
      for (int c = 0; c <= 140; c++) begin
         step(1'b1, c == 0, 0);
         if (out_valid === 1'b1) begin nv++; if (fv < 0) fv = c; lv = c; end
         if (exp_v[g_cyc]) begin nvm++; if (fvm < 0) fvm = c; lvm = c; end
         if (c == 2) begin
            lit("c2_start", 32'(out_start), 32'(exp_s[g_cyc]), 32'd1);
            lit("c2_valid", 32'(out_valid), 32'(exp_v[g_cyc]), 32'd1);
            lit("c2_lane1", out_p[1], exp_d[g_cyc][1], 32'd8);
            lit("c2_lane16", out_p[16], exp_d[g_cyc][16], 32'd100);
            lit("c2_lane17", out_p[17], exp_d[g_cyc][17], 32'd108);
         end
         if (c == 3) begin
            lit("c3_lane0", out_p[0], exp_d[g_cyc][0], 32'd16);
            lit("c3_lane1", out_p[1], exp_d[g_cyc][1], 32'd24);
            lit("c3_lane17", out_p[17], exp_d[g_cyc][17], 32'd124);
         end
         if (c == 130) lit("c130_lane0", out_p[0], exp_d[g_cyc][0], 32'd0);
      end
      lit("frame_nvalid", 32'(nv), 32'(nvm), 32'd128);
      lit("frame_first", 32'(fv), 32'(fvm), 32'd2);
      lit("frame_last", 32'(lv), 32'(lvm), 32'd129);

      // back-to-back frames
      base = g_cyc + 1; nv = 0; nvm = 0; fv = -1; fvm = -1; lv = -1; lvm = -1; ns = 0; nsm = 0;
      for (int c = 0; c <= 262; c++) begin
         step(1'b1, c == 0 || c == 128, 0);
         if (out_valid === 1'b1) begin nv++; if (fv < 0) fv = c; lv = c; end
         if (exp_v[g_cyc]) begin nvm++; if (fvm < 0) fvm = c; lvm = c; end
         if (out_start === 1'b1) ns++;
         if (exp_s[g_cyc]) nsm++;
         if (c == 130) lit("b2b_start130", 32'(out_start), 32'(exp_s[g_cyc]), 32'd1);
      end
      lit("b2b_nvalid", 32'(nv), 32'(nvm), 32'd256);
      lit("b2b_first", 32'(fv), 32'(fvm), 32'd2);
      lit("b2b_last", 32'(lv), 32'(lvm), 32'd257);
      lit("b2b_nstart", 32'(ns), 32'(nsm), 32'd2);

      // truncated pair: restart at phase 5 drops the A taken at phase 4
      base = g_cyc + 1;
      for (int c = 0; c <= 140; c++) begin
         step(1'b1, c == 0 || c == 5, 0);
         if (c == 5) lit("tr_c5_valid", 32'(out_valid), 32'(exp_v[g_cyc]), 32'd1);
         if (c == 6) begin
            lit("tr_c6_valid", 32'(out_valid), 32'(exp_v[g_cyc]), 32'd0);
            lit("tr_c6_lane0", out_p[0], exp_d[g_cyc][0], 32'd0);
         end
         if (c == 7) begin
            lit("tr_c7_start", 32'(out_start), 32'(exp_s[g_cyc]), 32'd1);
            lit("tr_c7_lane1", out_p[1], exp_d[g_cyc][1], 32'd508);
            lit("tr_c7_lane16", out_p[16], exp_d[g_cyc][16], 32'd600);
         end
      end

      // asynchronous reset mid-frame, then a fresh frame
      base = g_cyc + 1; nv = 0; ns = 0;
      for (int c = 0; c <= 60; c++) begin
         step(!(c >= 40 && c <= 45), c == 0 || c == 50, 0);
         if (c == 40) begin
            lit("ar_c40_valid", 32'(out_valid), 32'(exp_v[g_cyc]), 32'd0);
            lit("ar_c40_lane3", out_p[3], exp_d[g_cyc][3], 32'd0);
         end
         if (c > 40 && c <= 51 && out_valid !== 1'b0) nv++;
         if (c > 40 && out_start === 1'b1) ns++;
         if (c == 52) lit("ar_c52_start", 32'(out_start), 32'(exp_s[g_cyc]), 32'd1);
      end
      lit("ar_valid_gap", 32'(nv), 32'd0, 32'd0);
      lit("ar_nstart", 32'(ns), 32'd1, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
